// File: rtl/button_bank.sv
// button_bank: multi-channel push-button conditioner.
// Each channel synchronises one raw pin, debounces it, and classifies the
// debounced level into press / release / long-press / auto-repeat pulses.
// All event outputs are registered one-cycle pulses; channels never interact.
module button_bank #(
    parameter int N_BTN        = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 300,
    parameter int HOLD_CYC     = 2400000,
    parameter int REPEAT_CYC   = 480000,
    parameter int REPEAT_EN    = 1
) (
    input  logic             Fg_CLK,
    input  logic             RESETn,
    input  logic [N_BTN-1:0] ExtBTN,
    output logic [N_BTN-1:0] btn_lvl_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_o,
    output logic [N_BTN-1:0] rpt_o
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int HC_W     = $clog2(HOLD_MAX + 1);

    // Terminal counts: the event fires on the edge where the count reaches N.
    localparam logic [DB_W-1:0] DB_TC   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HC_W-1:0] HOLD_TC = HC_W'(HOLD_CYC - 1);
    localparam logic [HC_W-1:0] REP_TC  = HC_W'(REPEAT_CYC - 1);

    // Pin value meaning "released"; also the xor mask that maps pin -> pressed.
    localparam logic REL_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_e;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic            s1_q, s2_q;
        logic            p_s;
        logic            flip_s;
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            lvl_q, lvl_d;
        state_e          state_q, state_d;
        logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
        logic            press_q, press_d;
        logic            rel_q, rel_d;
        logic            long_q, long_d;
        logic            rpt_q, rpt_d;

        // Two-flop synchroniser; resets to the released pin level so the
        // first sample after reset never looks like a press edge.
        always_ff @(posedge Fg_CLK or negedge RESETn) begin
            if (!RESETn) begin
                s1_q <= REL_PIN;
                s2_q <= REL_PIN;
            end else begin
                s1_q <= ExtBTN[g];
                s2_q <= s1_q;
            end
        end

        assign p_s = s2_q ^ REL_PIN;

        // Debounce: count consecutive samples disagreeing with the accepted level.
        always_comb begin
            db_cnt_d = db_cnt_q;
            lvl_d    = lvl_q;
            flip_s   = 1'b0;
            if (p_s == lvl_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_TC) begin
                db_cnt_d = '0;
                lvl_d    = ~lvl_q;
                flip_s   = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Classification FSM; a debounced level change overrides any pending
        // long/repeat event in the same cycle.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            press_d    = 1'b0;
            rel_d      = 1'b0;
            long_d     = 1'b0;
            rpt_d      = 1'b0;
            if (flip_s && lvl_d) begin
                state_d    = ST_PRESSED;
                hold_cnt_d = '0;
                press_d    = 1'b1;
            end else if (flip_s) begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
                rel_d      = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        hold_cnt_d = '0;
                    end
                    ST_PRESSED: begin
                        if (hold_cnt_q == HOLD_TC) begin
                            hold_cnt_d = '0;
                            long_d     = 1'b1;
                            state_d    = ST_HELD;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (REPEAT_EN == 0) begin
                            hold_cnt_d = '0;
                        end else if (hold_cnt_q == REP_TC) begin
                            hold_cnt_d = '0;
                            rpt_d      = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end
                endcase
            end
        end

        // State, counters and registered event outputs.
        always_ff @(posedge Fg_CLK or negedge RESETn) begin
            if (!RESETn) begin
                db_cnt_q   <= '0;
                lvl_q      <= 1'b0;
                state_q    <= ST_IDLE;
                hold_cnt_q <= '0;
                press_q    <= 1'b0;
                rel_q      <= 1'b0;
                long_q     <= 1'b0;
                rpt_q      <= 1'b0;
            end else begin
                db_cnt_q   <= db_cnt_d;
                lvl_q      <= lvl_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                press_q    <= press_d;
                rel_q      <= rel_d;
                long_q     <= long_d;
                rpt_q      <= rpt_d;
            end
        end

        assign btn_lvl_o[g] = lvl_q;
        assign press_o[g]   = press_q;
        assign release_o[g] = rel_q;
        assign long_o[g]    = long_q;
        assign rpt_o[g]     = rpt_q;
    end

endmodule
